// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake plus decoded payload of the decode stage
interface decode_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 5
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [XLEN-1:0]       in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [REG_ADDR_W-1:0] out_rs1;
  logic [REG_ADDR_W-1:0] out_rs2;
  logic [XLEN-1:0]       out_imm;
  logic [ALU_OP_W-1:0]   out_alu_op;
  logic                  out_alu_src;
  logic                  out_reg_write;
  logic                  out_is_branch;
  logic                  out_jal;
  logic                  out_jalr;
  logic [2:0]            out_b_type;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic [2:0]            out_mem_size;
  logic                  out_illegal;
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm, out_alu_op,
           out_alu_src, out_reg_write, out_is_branch, out_jal, out_jalr, out_b_type,
           out_mem_read, out_mem_write, out_mem_size, out_illegal
  );
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm, out_alu_op,
           out_alu_src, out_reg_write, out_is_branch, out_jal, out_jalr, out_b_type,
           out_mem_read, out_mem_write, out_mem_size, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder with 2-entry skid buffer; define DECODE_MULDIV_EN to decode the M extension
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 5
) (
  input logic clk,
  input logic rst,
  decode_stage_if.slave bus
);
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       imm;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  alu_src;
    logic                  reg_write;
    logic                  is_branch;
    logic                  jal;
    logic                  jalr;
    logic [2:0]            b_type;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            mem_size;
    logic                  illegal;
  } bundle_t;
  logic [31:0] ins;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [REG_ADDR_W-1:0] rd_f, rs1_f, rs2_f;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [4:0]  r_code, i_code;
  logic        r_ok, i_ok, ill;
  bundle_t     d, main_q, skid_q;
  logic [XLEN-1:0] main_pc, skid_pc;
  logic        main_valid, skid_valid, in_fire, load;
  assign ins   = bus.in_instr;
  assign op    = ins[6:0];
  assign f3    = ins[14:12];
  assign f7    = ins[31:25];
  assign rd_f  = REG_ADDR_W'(ins[11:7]);
  assign rs1_f = REG_ADDR_W'(ins[19:15]);
  assign rs2_f = REG_ADDR_W'(ins[24:20]);
  assign imm_i = XLEN'($signed(ins[31:20]));
  assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
  always_comb begin
    case (f3)
      3'd0:    r_code = f7[5] ? 5'd1 : 5'd0;
      3'd1:    r_code = 5'd5;
      3'd2:    r_code = 5'd8;
      3'd3:    r_code = 5'd9;
      3'd4:    r_code = 5'd2;
      3'd5:    r_code = f7[5] ? 5'd7 : 5'd6;
      3'd6:    r_code = 5'd3;
      default: r_code = 5'd4;
    endcase
    case (f3)
      3'd0:    i_code = 5'd10;
      3'd1:    i_code = 5'd14;
      3'd2:    i_code = 5'd17;
      3'd3:    i_code = 5'd18;
      3'd4:    i_code = 5'd11;
      3'd5:    i_code = f7[5] ? 5'd16 : 5'd15;
      3'd6:    i_code = 5'd12;
      default: i_code = 5'd13;
    endcase
  end
  // funct7 0100000 is only meaningful for ADD/SUB and SRL/SRA (and SRLI/SRAI)
  assign r_ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
  assign i_ok = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
  always_comb begin
    d   = '0;
    ill = 1'b0;
    case (op)
      7'b0110011: begin
        d.rd = rd_f; d.rs1 = rs1_f; d.rs2 = rs2_f; d.reg_write = 1'b1;
        d.alu_op = ALU_OP_W'(r_code);
`ifdef DECODE_MULDIV_EN
        if (f7 == 7'h01) d.alu_op = ALU_OP_W'({2'b11, f3});
        ill = !r_ok && f7 != 7'h01;
`else
        ill = !r_ok;
`endif
      end
      7'b0010011: begin
        d.rd = rd_f; d.rs1 = rs1_f; d.imm = imm_i; d.alu_src = 1'b1; d.reg_write = 1'b1;
        d.alu_op = ALU_OP_W'(i_code);
        ill = !i_ok;
      end
      7'b0000011: begin
        d.rd = rd_f; d.rs1 = rs1_f; d.imm = imm_i; d.alu_op = ALU_OP_W'(5'b10101);
        d.mem_read = 1'b1; d.reg_write = 1'b1; d.alu_src = 1'b1; d.mem_size = f3;
        ill = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
      end
      7'b0100011: begin
        d.rs1 = rs1_f; d.rs2 = rs2_f; d.imm = imm_s; d.alu_op = ALU_OP_W'(5'b10101);
        d.mem_write = 1'b1; d.alu_src = 1'b1; d.mem_size = f3;
        ill = f3 >= 3'd3;
      end
      7'b1100011: begin
        d.rs1 = rs1_f; d.rs2 = rs2_f; d.imm = imm_b; d.is_branch = 1'b1; d.b_type = f3;
        ill = f3 == 3'd2 || f3 == 3'd3;
      end
      7'b1101111: begin
        d.rd = rd_f; d.imm = imm_j; d.jal = 1'b1; d.reg_write = 1'b1;
      end
      7'b1100111: begin
        d.rd = rd_f; d.rs1 = rs1_f; d.imm = imm_i; d.jalr = 1'b1; d.reg_write = 1'b1;
        ill = f3 != 3'd0;
      end
      7'b0110111: begin
        d.rd = rd_f; d.imm = imm_u; d.alu_op = ALU_OP_W'(5'b10011); d.alu_src = 1'b1; d.reg_write = 1'b1;
      end
      7'b0010111: begin
        d.rd = rd_f; d.imm = imm_u; d.alu_op = ALU_OP_W'(5'b10100); d.alu_src = 1'b1; d.reg_write = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      d = '0;
      d.illegal = 1'b1;
    end
  end
  assign in_fire = bus.in_valid && !skid_valid;
  assign load    = !main_valid || bus.out_ready;
  // skid is only written while main is held, and in_ready is low while it is occupied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      main_pc    <= '0;
      skid_pc    <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load) begin
      main_valid <= skid_valid || in_fire;
      skid_valid <= 1'b0;
      if (skid_valid) begin
        main_q  <= skid_q;
        main_pc <= skid_pc;
      end else if (in_fire) begin
        main_q  <= d;
        main_pc <= bus.in_pc;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_q     <= d;
      skid_pc    <= bus.in_pc;
    end
  end
  assign bus.in_ready      = !skid_valid;
  assign bus.out_valid     = main_valid;
  assign bus.out_pc        = main_pc;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_rs1       = main_q.rs1;
  assign bus.out_rs2       = main_q.rs2;
  assign bus.out_imm       = main_q.imm;
  assign bus.out_alu_op    = main_q.alu_op;
  assign bus.out_alu_src   = main_q.alu_src;
  assign bus.out_reg_write = main_q.reg_write;
  assign bus.out_is_branch = main_q.is_branch;
  assign bus.out_jal       = main_q.jal;
  assign bus.out_jalr      = main_q.jalr;
  assign bus.out_b_type    = main_q.b_type;
  assign bus.out_mem_read  = main_q.mem_read;
  assign bus.out_mem_write = main_q.mem_write;
  assign bus.out_mem_size  = main_q.mem_size;
  assign bus.out_illegal   = main_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors against hand-decoded RV32I expectations
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  decode_stage_if #(.XLEN(32), .REG_ADDR_W(5), .ALU_OP_W(5)) bus ();
  decode_stage #(.XLEN(32), .REG_ADDR_W(5), .ALU_OP_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc    = pc;
  endtask
  task automatic drain();
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    cyc();
  endtask
  initial begin
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    cyc();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_imm", bus.out_imm, 32'd0);
    rst = 1'b0;
    cyc();
    drive(1'b1, 32'h00500093, 32'h100);
    cyc();
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_op", 32'(bus.out_alu_op), 32'h0A);
    chk("addi_rd", 32'(bus.out_rd), 32'd1);
    chk("addi_imm", bus.out_imm, 32'd5);
    chk("addi_src", 32'(bus.out_alu_src), 32'd1);
    chk("addi_wr", 32'(bus.out_reg_write), 32'd1);
    chk("addi_pc", bus.out_pc, 32'h100);
    drain();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h104);
    cyc();
    chk("add_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 32'h402081B3, 32'h108);
    cyc();
    chk("skid_ready", 32'(bus.in_ready), 32'd0);
    chk("hold_op", 32'(bus.out_alu_op), 32'h00);
    chk("hold_rd", 32'(bus.out_rd), 32'd3);
    chk("hold_rs2", 32'(bus.out_rs2), 32'd2);
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    chk("hold2_pc", bus.out_pc, 32'h104);
    bus.out_ready = 1'b1;
    cyc();
    chk("sub_valid", 32'(bus.out_valid), 32'd1);
    chk("sub_op", 32'(bus.out_alu_op), 32'h01);
    chk("sub_pc", bus.out_pc, 32'h108);
    chk("sub_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    chk("empty_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 32'hFFFFFFFF, 32'h200);
    cyc();
    chk("ffff_ill", 32'(bus.out_illegal), 32'd1);
    chk("ffff_wr", 32'(bus.out_reg_write), 32'd0);
    chk("ffff_op", 32'(bus.out_alu_op), 32'd0);
    chk("ffff_pc", bus.out_pc, 32'h200);
    drive(1'b1, 32'h40209033, 32'h204);
    cyc();
    chk("f7_ill", 32'(bus.out_illegal), 32'd1);
    chk("f7_rs1", 32'(bus.out_rs1), 32'd0);
    drive(1'b1, 32'h00209033, 32'h208);
    cyc();
    chk("sll_ill", 32'(bus.out_illegal), 32'd0);
    chk("sll_op", 32'(bus.out_alu_op), 32'h05);
    drive(1'b1, 32'h022081B3, 32'h20C);
    cyc();
`ifdef DECODE_MULDIV_EN
    chk("mul_op", 32'(bus.out_alu_op), 32'h18);
    chk("mul_ill", 32'(bus.out_illegal), 32'd0);
`else
    chk("mul_op", 32'(bus.out_alu_op), 32'h00);
    chk("mul_ill", 32'(bus.out_illegal), 32'd1);
`endif
    drive(1'b1, 32'h0011A223, 32'h300);
    cyc();
    chk("sw_wr", 32'(bus.out_mem_write), 32'd1);
    chk("sw_size", 32'(bus.out_mem_size), 32'd2);
    chk("sw_imm", bus.out_imm, 32'd4);
    chk("sw_rs1", 32'(bus.out_rs1), 32'd3);
    chk("sw_rs2", 32'(bus.out_rs2), 32'd1);
    chk("sw_rd", 32'(bus.out_rd), 32'd0);
    chk("sw_op", 32'(bus.out_alu_op), 32'h15);
    drive(1'b1, 32'hFE000EE3, 32'h304);
    cyc();
    chk("beq_br", 32'(bus.out_is_branch), 32'd1);
    chk("beq_imm", bus.out_imm, 32'hFFFFFFFC);
    chk("beq_wr", 32'(bus.out_reg_write), 32'd0);
    drive(1'b1, 32'hFF812283, 32'h308);
    cyc();
    chk("lw_rd", 32'(bus.out_mem_read), 32'd1);
    chk("lw_imm", bus.out_imm, 32'hFFFFFFF8);
    chk("lw_dst", 32'(bus.out_rd), 32'd5);
    drive(1'b1, 32'h008000EF, 32'h30C);
    cyc();
    chk("jal_j", 32'(bus.out_jal), 32'd1);
    chk("jal_imm", bus.out_imm, 32'd8);
    chk("jal_pc", bus.out_pc, 32'h30C);
    drive(1'b1, 32'h00002063, 32'h310);
    cyc();
    chk("blt_ill", 32'(bus.out_illegal), 32'd1);
    drain();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h400);
    cyc();
    drive(1'b1, 32'h002081B3, 32'h404);
    cyc();
    chk("fl_full", 32'(bus.in_ready), 32'd0);
    bus.flush = 1'b1;
    drive(1'b1, 32'h402081B3, 32'h408);
    cyc();
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_ready", 32'(bus.in_ready), 32'd1);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h123452B7, 32'h40C);
    cyc();
    chk("lui_valid", 32'(bus.out_valid), 32'd1);
    chk("lui_pc", bus.out_pc, 32'h40C);
    chk("lui_op", 32'(bus.out_alu_op), 32'h13);
    chk("lui_imm", bus.out_imm, 32'h12345000);
    bus.flush = 1'b1;
    drive(1'b1, 32'h00500093, 32'h410);
    cyc();
    chk("fl2_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0;
    drive(1'b1, 32'h00500093, 32'h500);
    cyc();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_rd", 32'(bus.out_rd), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
